// File: rtl/uart_msg_ctrl.sv
// uart_msg_ctrl: message-level wrapper around a byte UART.
// TX serialises an NBYTES message MSB-byte first through a strobe/busy handshake.
// RX assembles bytes into messages, terminated by count, by TERM, or dropped on idle timeout.
module uart_msg_ctrl #(
  parameter int unsigned NBYTES  = 10,
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [7:0]  TERM    = 8'h0D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NBYTES-1:0]   tx_msg,
  input  logic                  tx_req,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_stb,
  input  logic                  uart_tx_busy,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_valid,
  output logic [8*NBYTES-1:0]   rx_msg,
  output logic [3:0]            rx_len,
  output logic                  rx_valid,
  output logic                  rx_err
);

  localparam int unsigned MW = 8 * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STB,
    GAP,
    WAITB
  } tx_state_t;

  tx_state_t         tx_state;
  logic [MW-1:0]     tx_sh;
  logic [CW-1:0]     tx_cnt;

  logic [MW-1:0]     rx_sh;
  logic [MW-1:0]     rx_shift;
  logic [CW-1:0]     rx_cnt;
  logic [TW-1:0]     rx_tmr;

  // Shift register with the new byte entering at the low end.
  assign rx_shift = MW'({rx_sh, uart_rx_data});

  // TX sequencer: registered outputs, so uart_tx_stb is high exactly while in STB
  // (it is set on the LOAD->STB transition and cleared by the default next cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state     <= IDLE;
      tx_sh        <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      uart_tx_stb  <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      tx_done     <= 1'b0;
      uart_tx_stb <= 1'b0;
      case (tx_state)
        IDLE: begin
          if (tx_req) begin
            tx_sh    <= tx_msg;
            tx_cnt   <= '0;
            tx_busy  <= 1'b1;
            tx_state <= LOAD;
          end
        end
        LOAD: begin
          uart_tx_data <= tx_sh[MW-1 -: 8];
          uart_tx_stb  <= 1'b1;
          tx_state     <= STB;
        end
        STB: begin
          tx_state <= GAP;
        end
        GAP: begin
          tx_state <= WAITB;
        end
        WAITB: begin
          if (!uart_tx_busy) begin
            if (tx_cnt == LAST_BYTE) begin
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              tx_state <= IDLE;
            end else begin
              tx_sh    <= tx_sh << 8;
              tx_cnt   <= tx_cnt + CW'(1);
              tx_state <= LOAD;
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // RX assembler and inter-byte idle timer; an arriving byte always beats timer expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sh    <= '0;
      rx_cnt   <= '0;
      rx_tmr   <= '0;
      rx_msg   <= '0;
      rx_len   <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (uart_rx_valid) begin
        rx_tmr <= '0;
        if (uart_rx_data == TERM) begin
          if (rx_cnt != '0) begin
            // Only the low rx_cnt bytes are live; shifting them to the top
            // also pushes stale upper bytes out and zero-fills the tail.
            rx_msg   <= rx_sh << (MW - 8 * 32'(rx_cnt));
            rx_len   <= 4'(rx_cnt);
            rx_valid <= 1'b1;
            rx_cnt   <= '0;
          end
        end else if (rx_cnt == LAST_BYTE) begin
          rx_msg   <= rx_shift;
          rx_len   <= 4'(NBYTES);
          rx_valid <= 1'b1;
          rx_cnt   <= '0;
        end else begin
          rx_sh  <= rx_shift;
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else if (rx_cnt != '0) begin
        if (rx_tmr == LAST_TICK) begin
          rx_err <= 1'b1;
          rx_cnt <= '0;
          rx_tmr <= '0;
        end else begin
          rx_tmr <= rx_tmr + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_msg_ctrl.sv
// tb_uart_msg_ctrl: scoreboard bench for uart_msg_ctrl with a message-level reference model.
module tb_uart_msg_ctrl;

  localparam int NB = 10;
  localparam int TO = 50;
  localparam logic [7:0] TERM_B = 8'h0D;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] tx_msg;
  logic        tx_req;
  logic        tx_busy;
  logic        tx_done;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_stb;
  logic        uart_tx_busy;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic [79:0] rx_msg;
  logic [3:0]  rx_len;
  logic        rx_valid;
  logic        rx_err;

  always #5 clk = ~clk;

  uart_msg_ctrl #(.NBYTES(NB), .TIMEOUT(TO), .TERM(TERM_B)) dut (
    .clk(clk), .rst(rst),
    .tx_msg(tx_msg), .tx_req(tx_req), .tx_busy(tx_busy), .tx_done(tx_done),
    .uart_tx_data(uart_tx_data), .uart_tx_stb(uart_tx_stb), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .rx_msg(rx_msg), .rx_len(rx_len), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  typedef struct {
    bit          is_err;
    logic [79:0] msg;
    int          len;
  } rx_ev_t;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard state
  logic [7:0]  tx_q[$];
  rx_ev_t      rx_q[$];
  int          done_pending = 0;
  int          tx_bytes = 0;
  int          stb_total = 0;
  int          busy_len = 3;
  int          busy_cnt = 0;
  logic [79:0] last_msg = '0;
  int          last_len = 0;

  // reference model state for RX
  logic [7:0]  part[$];
  int          idle_cnt = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  task automatic push_tx_exp(input logic [79:0] m);
    for (int i = 0; i < NB; i++) tx_q.push_back(m[79-8*i -: 8]);
    done_pending++;
  endtask

  task automatic publish_part();
    rx_ev_t ev;
    ev.is_err = 1'b0;
    ev.msg = '0;
    foreach (part[i]) ev.msg[79-8*i -: 8] = part[i];
    ev.len = part.size();
    rx_q.push_back(ev);
    part.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    idle_cnt = 0;
    if (b == TERM_B) begin
      if (part.size() > 0) publish_part();
    end else begin
      part.push_back(b);
      if (part.size() == NB) publish_part();
    end
  endtask

  task automatic model_idle();
    rx_ev_t ev;
    idle_cnt++;
    if (part.size() > 0 && idle_cnt == TO) begin
      ev.is_err = 1'b1;
      ev.msg = '0;
      ev.len = 0;
      rx_q.push_back(ev);
      part.delete();
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_data = b;
    uart_rx_valid = 1'b1;
    model_byte(b);
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic rx_idle(input int n);
    repeat (n) begin
      model_idle();
      @(negedge clk);
    end
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while ((done_pending != 0 || tx_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain_bound", n < 20000, 1);
  endtask

  task automatic send_tx(input logic [79:0] m);
    wait_tx_drain();
    tx_msg = m;
    tx_req = 1'b1;
    push_tx_exp(m);
    @(negedge clk);
    check("tx_accept", tx_busy, 1);
    tx_req = 1'b0;
    tx_msg = rand80();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_busy"}, tx_busy, 0);
    check({name, "_tx_done"}, tx_done, 0);
    check({name, "_uart_tx_stb"}, uart_tx_stb, 0);
    check({name, "_uart_tx_data"}, uart_tx_data, 0);
    check({name, "_rx_valid"}, rx_valid, 0);
    check({name, "_rx_err"}, rx_err, 0);
    check({name, "_rx_msg"}, rx_msg, 0);
    check({name, "_rx_len"}, rx_len, 0);
  endtask

  // Monitor + UART busy responder, sampling 1 time unit after each rising edge.
  initial begin
    rx_ev_t ev;
    uart_tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        uart_tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        uart_tx_busy = 1'b0;
      end
      if (uart_tx_stb) begin
        stb_total++;
        check("tx_stb_expected", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) check("tx_byte", uart_tx_data, tx_q.pop_front());
        check("tx_busy_during_stb", tx_busy, 1);
        tx_bytes++;
        busy_cnt = busy_len;
      end
      if (tx_done) begin
        check("tx_done_expected", done_pending > 0, 1);
        check("tx_done_bytes", tx_bytes, NB);
        check("tx_busy_at_done", tx_busy, 0);
        if (done_pending > 0) done_pending--;
        tx_bytes = 0;
      end
      if (rx_valid) begin
        check("rx_valid_expected", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          ev = rx_q.pop_front();
          check("rx_event_is_msg", ev.is_err, 0);
          check("rx_msg", rx_msg, ev.msg);
          check("rx_len", rx_len, ev.len);
          last_msg = ev.msg;
          last_len = ev.len;
        end
      end
      if (rx_err) begin
        check("rx_err_expected", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          ev = rx_q.pop_front();
          check("rx_event_is_err", ev.is_err, 1);
          check("rx_msg_held", rx_msg, last_msg);
          check("rx_len_held", rx_len, last_len);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int n;
    int base;
    logic [79:0] m1;
    logic [79:0] m2;
    rst = 1'b0;
    tx_req = 1'b0;
    tx_msg = '0;
    uart_rx_valid = 1'b0;
    uart_rx_data = '0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // directed TX with a slow UART, request on the first cycle out of reset
    busy_len = 100;
    send_tx(80'h41_42_43_44_45_46_47_48_49_4A);
    wait_tx_drain();
    busy_len = 3;

    // RX full-length message
    for (int i = 0; i < NB; i++) rx_byte(8'(8'h30 + i));
    rx_idle(3);

    // RX early termination, then a lone terminator
    rx_byte(8'h61);
    rx_byte(8'h62);
    rx_byte(TERM_B);
    rx_idle(2);
    rx_byte(TERM_B);
    rx_idle(3);

    // RX timeout, then a byte landing exactly on the expiry cycle
    rx_byte(8'h41);
    rx_idle(TO + 3);
    rx_byte(8'h42);
    rx_idle(TO - 1);
    rx_byte(8'h43);
    rx_byte(TERM_B);
    rx_idle(3);

    // back-to-back messages with tx_req held high
    busy_len = 2;
    wait_tx_drain();
    m1 = rand80();
    m2 = rand80();
    tx_msg = m1;
    tx_req = 1'b1;
    push_tx_exp(m1);
    @(negedge clk);
    check("b2b_accept", tx_busy, 1);
    tx_msg = m2;
    push_tx_exp(m2);
    n = 0;
    while (!tx_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", tx_done, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("b2b_reaccept", tx_busy, 1);
        tx_req = 1'b0;
        tx_msg = rand80();
      end
    end while (!uart_tx_stb && n < 10);
    check("b2b_idle_gap", n, 2);
    wait_tx_drain();

    // concurrent random TX and RX traffic
    fork
      begin
        for (int m = 0; m < 4; m++) begin
          busy_len = $urandom_range(0, 5);
          send_tx(rand80());
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_tx_drain();
      end
      begin
        for (int k = 0; k < 80; k++) begin
          if ($urandom_range(0, 19) == 0) rx_idle($urandom_range(TO - 2, TO + 2));
          else rx_idle($urandom_range(0, 3));
          if ($urandom_range(0, 4) == 0) rx_byte(TERM_B);
          else rx_byte(8'($urandom_range(32, 126)));
        end
        rx_idle(TO + 5);
      end
    join

    // reset in the middle of TX byte 4 and RX byte 3
    busy_len = 20;
    send_tx(rand80());
    base = stb_total;
    n = 0;
    while (stb_total < base + 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_reached_byte4", stb_total >= base + 4, 1);
    rx_byte(8'h71);
    rx_byte(8'h72);
    uart_rx_data = 8'h73;
    uart_rx_valid = 1'b1;
    rst = 1'b0;
    tx_q.delete();
    done_pending = 0;
    tx_bytes = 0;
    part.delete();
    idle_cnt = 0;
    busy_cnt = 0;
    last_msg = '0;
    last_len = 0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    uart_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    busy_len = 3;
    send_tx(rand80());
    wait_tx_drain();

    // drain and confirm nothing is outstanding
    rx_idle(TO + 5);
    repeat (5) @(negedge clk);
    check("tx_queue_empty", tx_q.size(), 0);
    check("rx_queue_empty", rx_q.size(), 0);
    check("done_pending_zero", done_pending, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_msg_ctrl.md
UART_MSG_CTRL -- requirements
Module: uart_msg_ctrl

Interface
REQ-001 Parameter NBYTES, 10: message length in bytes; message width is 8*NBYTES bits (80 at default).
REQ-002 Parameter TIMEOUT, 1000000: idle clk cycles allowed between received bytes of one message.
REQ-003 Parameter TERM, 8'h0D: receive byte that terminates a message early.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 tx_msg  in  80  message to transmit; byte tx_msg[79:72] is sent first.
REQ-007 tx_req  in  1  level request to send tx_msg.
REQ-008 tx_busy  out  1  high from request acceptance until tx_done.
REQ-009 tx_done  out  1  one-cycle pulse after the last byte completes.
REQ-010 uart_tx_data  out  8  byte presented to the UART transmitter.
REQ-011 uart_tx_stb  out  1  one-cycle strobe; UART latches uart_tx_data.
REQ-012 uart_tx_busy  in  1  UART transmitter busy; rises the cycle after uart_tx_stb.
REQ-013 uart_rx_data  in  8  received byte; valid only with uart_rx_valid.
REQ-014 uart_rx_valid  in  1  one-cycle pulse per received byte.
REQ-015 rx_msg  out  80  last assembled message, left-aligned, zero-padded.
REQ-016 rx_len  out  4  number of bytes in rx_msg, 1..NBYTES.
REQ-017 rx_valid  out  1  one-cycle pulse when rx_msg/rx_len update.
REQ-018 rx_err  out  1  one-cycle pulse when a partial message is dropped on timeout.

Function
REQ-019 The TX FSM SHALL use states IDLE, LOAD, STB, GAP, WAITB.
REQ-020 In IDLE with tx_req=1: latch tx_msg into a shift register, clear the byte counter, assert tx_busy, go to LOAD.
REQ-021 LOAD: drive the top byte on uart_tx_data, go to STB.
REQ-022 STB: assert uart_tx_stb for exactly one cycle, go to GAP.
REQ-023 GAP: ignore uart_tx_busy for one cycle, go to WAITB.
REQ-024 WAITB with uart_tx_busy=0: if NBYTES bytes are sent, pulse tx_done, drop tx_busy, go to IDLE; otherwise shift left 8 bits, increment the counter, go to LOAD.
REQ-025 tx_req outside IDLE SHALL be ignored; a tx_req held through tx_done is accepted on the first IDLE cycle, starting a new message.
REQ-026 tx_msg changes after acceptance SHALL NOT affect the message in flight.
REQ-027 The RX assembler SHALL keep a byte count (0..NBYTES) and a byte shift register; each accepted byte shifts in at the low end.
REQ-028 Non-TERM byte with count<NBYTES-1: shift in, count+1.
REQ-029 Non-TERM byte with count=NBYTES-1: publish all NBYTES bytes, rx_len=NBYTES, pulse rx_valid next cycle, count=0.
REQ-030 TERM with count=k>0: publish the k bytes left-aligned (first byte at [79:72]), low bytes 8'h00, rx_len=k, pulse rx_valid, count=0; TERM is not stored.
REQ-031 TERM with count=0 SHALL be ignored with no pulse.
REQ-032 Idle timer: cleared on every uart_rx_valid; counts while count>0; at TIMEOUT it discards the partial message, pulses rx_err, and sets count=0; rx_msg is unchanged.
REQ-033 Simultaneous timeout expiry and uart_rx_valid: the byte wins, the timer clears, and there is no rx_err.
REQ-034 rx_msg and rx_len SHALL hold between messages.
REQ-035 TX and RX paths SHALL operate independently and concurrently.

Reset
REQ-036 On rst=0, immediately (asynchronously): TX FSM=IDLE; tx_busy, tx_done, uart_tx_stb, rx_valid, rx_err=0; uart_tx_data=8'h00; rx_msg=0; rx_len=0; counters and timer=0.
REQ-037 Reset mid-transmission SHALL abort without tx_done; reset mid-reception SHALL discard the partial message without rx_err.
REQ-038 After rst rises, the first tx_req is accepted on the next rising edge.

Verification
REQ-039 TX: tx_msg=80'h41_42_43_44_45_46_47_48_49_4A, tx_req one cycle, UART busy 100 cycles/byte -> 10 strobes carrying 41..4A in order, one tx_done, tx_busy high throughout.
REQ-040 RX full: bytes 30..39 -> one rx_valid, rx_msg=80'h30_31_32_33_34_35_36_37_38_39, rx_len=10, no rx_err.
REQ-041 RX early: 61,62,0D -> rx_valid, rx_msg=80'h6162_0000_0000_0000_0000, rx_len=2; a lone 0D -> no pulse.
REQ-042 RX timeout (TIMEOUT=50): byte 41, then 50 idle cycles -> rx_err pulse, rx_msg unchanged; byte arriving on the expiry cycle -> no rx_err.
REQ-043 rst low during byte 4 of TX and byte 3 of RX -> outputs at reset values, no tx_done/rx_err; a fresh tx_req afterwards sends all 10 bytes.
REQ-044 tx_req held high continuously -> back-to-back messages, exactly one IDLE cycle between tx_done and the next strobe sequence.
